// File: rtl/calc_pkg.sv
// Shared constants and types for the queue calculator command front end:
// ALU opcodes, queue op codes, reject/abort codes and sequencer state encoding.
package calc_pkg;

    localparam logic [2:0] PUSH     = 3'd0;
    localparam logic [2:0] POP      = 3'd1;
    localparam logic [2:0] ADD      = 3'd2;
    localparam logic [2:0] MULL     = 3'd3;
    localparam logic [2:0] SUB      = 3'd4;
    localparam logic [2:0] DIV      = 3'd5;
    localparam logic [2:0] REM      = 3'd6;
    localparam logic [2:0] NOP_CODE = 3'd7;

    localparam logic [1:0] Q_PUSH         = 2'd0;
    localparam logic [1:0] Q_SLEEP        = 2'd1;
    localparam logic [1:0] Q_GET_AND_PUSH = 2'd2;
    localparam logic [1:0] Q_POP          = 2'd3;

    localparam logic [1:0] ERR_ILLEGAL   = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Arithmetic ops consume two queue elements and leave one behind.
    function automatic logic is_arith(input logic [2:0] op);
        return (op >= ADD) && (op <= REM);
    endfunction

    function automatic logic is_divide(input logic [2:0] op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/calc_cmd_sequencer_if.sv
// Command stream and ALU issue bus of the calculator command sequencer.
interface calc_cmd_sequencer_if #(
    parameter int DATA_W = 8
);
    // Command handshake: a command transfers on a rising clk edge where
    // cmd_valid && cmd_ready; cmd_op/cmd_val must hold while valid && !ready.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DATA_W-1:0] cmd_val;

    logic                alu_sync;
    logic [2*DATA_W-1:0] alu_operands;
    logic [2:0]          alu_opcode;
    logic [DATA_W-1:0]   alu_push_val;

    modport master (
        output cmd_valid, cmd_op, cmd_val, alu_sync, alu_operands,
        input  cmd_ready, alu_opcode, alu_push_val
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_val, alu_sync, alu_operands,
        output cmd_ready, alu_opcode, alu_push_val
    );

endinterface

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO holding {op, val}; the head stays in place until
// the sequencer retires it, so the in-flight command occupies a slot.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Issues buffered calculator commands to the ALU one at a time, screening each
// against a shadow queue occupancy so only executable commands reach the ALU.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int Q_DEPTH   = 8,
    parameter int TIMEOUT   = 16,
    parameter int DATA_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    calc_cmd_sequencer_if.slave bus,
    output logic                busy,
    output logic [3:0]          q_count,
    output logic                done,
    output logic                err_valid,
    output logic [1:0]          err_code,
    output state_t              state_dbg
);

    localparam int         TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [3:0] Q_FULL = 4'(Q_DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [2+DATA_W:0]   head_word;
    logic [2:0]          head_op;
    logic [DATA_W-1:0]   head_val;
    logic [DATA_W-1:0]   divisor;
    logic [TO_W-1:0]     to_cnt;
    logic                timed_out;
    logic                chk_err;
    logic [1:0]          chk_code;
    logic                issue_go;
    logic                reject;
    logic                complete;
    logic                abort_cmd;

    assign bus.cmd_ready = !fifo_full;
    assign fifo_push     = bus.cmd_valid && !fifo_full;
    assign head_op       = head_word[2+DATA_W:DATA_W];
    assign head_val      = head_word[DATA_W-1:0];
    assign divisor       = bus.alu_operands[DATA_W-1:0];
    assign timed_out     = (to_cnt == TO_W'(TIMEOUT - 1));

    calc_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .W     (3 + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_push),
        .wr_data ({bus.cmd_op, bus.cmd_val}),
        .rd_en   (fifo_pop),
        .rd_data (head_word),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Screening of the FIFO head, first matching rule wins.
    always_comb begin
        chk_err  = 1'b0;
        chk_code = ERR_ILLEGAL;
        if (head_op == NOP_CODE) begin
            chk_err  = 1'b1;
            chk_code = ERR_ILLEGAL;
        end else if ((head_op == POP && q_count < 4'd1) ||
                     (is_arith(head_op) && q_count < 4'd2)) begin
            chk_err  = 1'b1;
            chk_code = ERR_UNDERFLOW;
        end else if (head_op == PUSH && q_count == Q_FULL) begin
            chk_err  = 1'b1;
            chk_code = ERR_OVERFLOW;
        end else if (is_divide(head_op) && divisor == '0) begin
            chk_err  = 1'b1;
            chk_code = ERR_OVERFLOW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (issue_go) state_nxt = ST_ISSUE;
            ST_ISSUE: if (complete || abort_cmd) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_ISSUE);
        state_dbg = state;
        issue_go  = 1'b0;
        reject    = 1'b0;
        complete  = 1'b0;
        abort_cmd = 1'b0;
        case (state)
            ST_IDLE: begin
                issue_go = !fifo_empty && !chk_err;
                reject   = !fifo_empty && chk_err;
            end
            ST_ISSUE: begin
                complete  = bus.alu_sync;
                abort_cmd = !bus.alu_sync && timed_out;
            end
            default: ;
        endcase
        // The head is retired only once it is finished with, never at issue.
        fifo_pop = reject || complete || abort_cmd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.alu_opcode   <= NOP_CODE;
            bus.alu_push_val <= '0;
            q_count          <= '0;
            done             <= 1'b0;
            err_valid        <= 1'b0;
            err_code         <= ERR_ILLEGAL;
            to_cnt           <= '0;
        end else begin
            done      <= 1'b0;
            err_valid <= 1'b0;
            if (reject) begin
                err_valid <= 1'b1;
                err_code  <= chk_code;
            end
            // The ALU queue input is count_val | push_val, so push_val must be zero unless pushing.
            if (issue_go) begin
                bus.alu_opcode   <= head_op;
                bus.alu_push_val <= (head_op == PUSH) ? head_val : '0;
                to_cnt           <= '0;
            end
            if (complete) begin
                done             <= 1'b1;
                q_count          <= (head_op == PUSH) ? q_count + 4'd1 : q_count - 4'd1;
                bus.alu_opcode   <= NOP_CODE;
                bus.alu_push_val <= '0;
            end
            if (abort_cmd) begin
                err_valid        <= 1'b1;
                err_code         <= ERR_TIMEOUT;
                bus.alu_opcode   <= NOP_CODE;
                bus.alu_push_val <= '0;
            end
            if (state == ST_ISSUE && !complete && !abort_cmd) to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: directed scenarios plus randomized command
// streams, responses scored against a queue-occupancy reference model.
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int CMD_DEPTH = 4;
    localparam int Q_DEPTH   = 8;
    localparam int TIMEOUT   = 16;
    localparam int DATA_W    = 8;
    localparam int WAIT_MAX  = 200;
    localparam int DRAIN_MAX = 600;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MULL = 3'd3;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_NOP  = 3'd7;

    typedef struct packed {
        logic       issues;
        logic       is_err;
        logic [1:0] code;
        logic [2:0] op;
        logic [7:0] val;
        logic       no_sync;
        logic [3:0] q_after;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [3:0] q_count;
    logic       done;
    logic       err_valid;
    logic [1:0] err_code;
    state_t     state_dbg;

    calc_cmd_sequencer_if #(.DATA_W(DATA_W)) bus();

    calc_cmd_sequencer #(
        .CMD_DEPTH (CMD_DEPTH),
        .Q_DEPTH   (Q_DEPTH),
        .TIMEOUT   (TIMEOUT),
        .DATA_W    (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .q_count   (q_count),
        .done      (done),
        .err_valid (err_valid),
        .err_code  (err_code),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int         n_checks       = 0;
    int         n_errors       = 0;
    exp_t       exp_q[$];
    int         m_q            = 0;
    int         alu_delay_max  = 0;
    int         alu_delay      = 0;
    bit         noise_en       = 1'b0;
    int         cyc            = 0;
    int         last_issue_cyc = 0;
    int         last_gap       = 0;
    int         busy_cycles    = 0;
    int         n_done         = 0;
    logic [1:0] last_err_code  = 2'd0;
    bit         busy_prev      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp_v);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {busy, done, err_valid, err_code, q_count, bus.alu_opcode,
                     bus.alu_push_val, bus.cmd_ready},
              {1'b0, 1'b0, 1'b0, 2'd0, 4'd0, OP_NOP, 8'h00, 1'b1});
    endtask

    task automatic apply_reset();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_outputs");
        exp_q.delete();
        m_q = 0;
        rst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Outcomes depend only on command order, the occupancy so far, the divisor
    // presented by the ALU and whether the ALU will answer, so they are known at send time.
    task automatic model_push(input logic [2:0] op, input logic [7:0] val, input bit no_sync);
        exp_t e;
        bit   arith;
        e         = '0;
        e.op      = op;
        e.val     = val;
        e.no_sync = no_sync;
        arith     = (op >= 3'd2) && (op <= 3'd6);
        if (op == OP_NOP) begin
            e.is_err = 1'b1; e.code = 2'd0;
        end else if ((op == OP_POP && m_q < 1) || (arith && m_q < 2)) begin
            e.is_err = 1'b1; e.code = 2'd1;
        end else if (op == OP_PUSH && m_q == Q_DEPTH) begin
            e.is_err = 1'b1; e.code = 2'd2;
        end else if ((op == 3'd5 || op == 3'd6) && bus.alu_operands[7:0] == 8'd0) begin
            e.is_err = 1'b1; e.code = 2'd2;
        end else begin
            e.issues = 1'b1;
            if (no_sync) begin
                e.is_err = 1'b1; e.code = 2'd3;
            end else begin
                m_q = (op == OP_PUSH) ? m_q + 1 : m_q - 1;
            end
        end
        e.q_after = 4'(m_q);
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] val, input bit no_sync);
        int waited = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_val   = val;
        while (!bus.cmd_ready && waited < WAIT_MAX) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            fail("cmd_accept_timeout", waited, WAIT_MAX);
            bus.cmd_valid = 1'b0;
            return;
        end
        model_push(op, val, no_sync);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < DRAIN_MAX) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) fail("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [2:0] rand_op();
        int r;
        r = $urandom_range(0, 15);
        if (r < 7)  return OP_PUSH;
        if (r < 9)  return OP_POP;
        if (r < 15) return 3'(2 + (r - 9) % 5);
        return OP_NOP;
    endfunction

    // ---------------- ALU responder ----------------
    initial begin : alu_model
        bus.alu_sync = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst || bus.alu_sync) begin
                bus.alu_sync = 1'b0;
            end else if (busy) begin
                if (exp_q.size() != 0 && !exp_q[0].no_sync) begin
                    if (alu_delay == 0) begin
                        bus.alu_sync = 1'b1;
                        alu_delay    = $urandom_range(0, alu_delay_max);
                    end else begin
                        alu_delay--;
                    end
                end
            end else if (noise_en && $urandom_range(0, 7) == 0) begin
                bus.alu_sync = 1'b1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                busy_prev = 1'b0;
                continue;
            end
            if (busy && !busy_prev) begin
                busy_cycles    = 0;
                last_gap       = cyc - last_issue_cyc;
                last_issue_cyc = cyc;
                if (exp_q.size() == 0) fail("unexpected_issue", 1, 0);
                else check("issue_allowed", busy, exp_q[0].issues);
            end
            if (busy) begin
                busy_cycles++;
                if (exp_q.size() != 0) begin
                    check("issue_opcode", bus.alu_opcode, exp_q[0].op);
                    check("issue_push_val", bus.alu_push_val,
                          (exp_q[0].op == OP_PUSH) ? exp_q[0].val : 8'h00);
                end
            end else begin
                check("idle_alu_outputs", {bus.alu_opcode, bus.alu_push_val}, {OP_NOP, 8'h00});
            end
            if (done || err_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_response", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_kind", {done, err_valid}, e.is_err ? 2'b01 : 2'b10);
                    if (e.is_err) begin
                        check("err_code", err_code, e.code);
                        last_err_code = err_code;
                        if (e.code == 2'd3) check("timeout_cycles", busy_cycles, TIMEOUT);
                    end else begin
                        n_done++;
                    end
                    check("q_count", q_count, e.q_after);
                end
            end
            busy_prev = busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int done_base;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 3'd0;
        bus.cmd_val      = 8'd0;
        bus.alu_operands = 16'h0304;
        apply_reset();

        // PUSH 1..4 with immediate ALU completion
        done_base = n_done;
        send_cmd(OP_PUSH, 8'd1, 1'b0);
        check("pre_issue_idle", busy, 1'b0);
        @(negedge clk);
        check("issue_latency", {busy, bus.alu_opcode, bus.alu_push_val}, {1'b1, OP_PUSH, 8'd1});
        for (int i = 2; i <= 4; i++) send_cmd(OP_PUSH, 8'(i), 1'b0);
        wait_drain();
        check("push4_q_count", q_count, 4'd4);
        check("push4_done_pulses", n_done - done_base, 4);
        check("back_to_back_gap", last_gap, 2);

        send_cmd(OP_ADD, 8'hAA, 1'b0);
        send_cmd(OP_MULL, 8'h55, 1'b0);
        wait_drain();
        check("arith_q_count", q_count, 4'd2);

        // underflow and illegal opcode straight from reset
        apply_reset();
        send_cmd(OP_ADD, 8'd0, 1'b0);
        send_cmd(OP_NOP, 8'd0, 1'b0);
        wait_drain();
        check("illegal_last_code", last_err_code, 2'd0);
        check("reject_q_count", q_count, 4'd0);

        // overflow on the ninth PUSH, then divide by zero
        for (int i = 0; i < 9; i++) send_cmd(OP_PUSH, 8'($urandom_range(0, 255)), 1'b0);
        wait_drain();
        check("overflow_code", last_err_code, 2'd2);
        check("full_q_count", q_count, 4'd8);
        bus.alu_operands = 16'h0500;
        send_cmd(OP_DIV, 8'd0, 1'b0);
        wait_drain();
        check("div0_code", last_err_code, 2'd2);
        check("div0_q_count", q_count, 4'd8);
        bus.alu_operands = 16'h0304;

        // stalled ALU: backpressure, timeout, then the queue resumes
        apply_reset();
        send_cmd(OP_PUSH, 8'h0A, 1'b1);
        send_cmd(OP_PUSH, 8'h0B, 1'b0);
        send_cmd(OP_PUSH, 8'h0C, 1'b0);
        send_cmd(OP_PUSH, 8'h0D, 1'b0);
        check("cmd_ready_when_full", bus.cmd_ready, 1'b0);
        send_cmd(OP_PUSH, 8'h0E, 1'b0);
        wait_drain();
        check("timeout_resume_q_count", q_count, 4'd4);
        check("timeout_last_code", last_err_code, 2'd3);

        // randomized streams; divisor only changes while drained
        alu_delay_max = 3;
        noise_en      = 1'b1;
        for (int ph = 0; ph < 6; ph++) begin
            bus.alu_operands = {8'($urandom_range(0, 255)),
                                (ph == 2) ? 8'd0 : 8'($urandom_range(1, 255))};
            for (int i = 0; i < 50; i++) begin
                send_cmd(rand_op(), 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            end
            wait_drain();
        end

        // asynchronous reset while a command is in flight
        noise_en = 1'b0;
        send_cmd(OP_PUSH, 8'h55, 1'b1);
        repeat (5) @(negedge clk);
        check("busy_before_reset", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset_mid_issue");
        exp_q.delete();
        m_q = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_state", {busy, done, err_valid, q_count}, {1'b0, 1'b0, 1'b0, 4'd0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
